// File: rtl/snax_dma_twod_expander.sv
// Buffers 2D DMA requests in a small FIFO and expands each one into a sequence
// of 1D bursts for the AXI DMA backend, flagging the final burst of every request.
module snax_dma_twod_expander #(
    parameter int unsigned AddrWidth    = 48,
    parameter int unsigned IdWidth      = 6,
    parameter int unsigned ReqFifoDepth = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 twod_valid_i,
    output logic                 twod_ready_o,
    input  logic [IdWidth-1:0]   twod_id_i,
    input  logic [AddrWidth-1:0] twod_src_i,
    input  logic [AddrWidth-1:0] twod_dst_i,
    input  logic [AddrWidth-1:0] twod_num_bytes_i,
    input  logic [AddrWidth-1:0] twod_stride_src_i,
    input  logic [AddrWidth-1:0] twod_stride_dst_i,
    input  logic [AddrWidth-1:0] twod_num_reps_i,
    input  logic                 twod_decouple_rw_i,
    input  logic                 twod_is_twod_i,
    output logic                 burst_valid_o,
    input  logic                 burst_ready_i,
    output logic [IdWidth-1:0]   burst_id_o,
    output logic [AddrWidth-1:0] burst_src_o,
    output logic [AddrWidth-1:0] burst_dst_o,
    output logic [AddrWidth-1:0] burst_num_bytes_o,
    output logic                 burst_decouple_rw_o,
    output logic                 burst_last_o,
    output logic                 busy_o
);

    localparam int unsigned PtrW = (ReqFifoDepth > 1) ? $clog2(ReqFifoDepth) : 1;
    localparam int unsigned CntW = $clog2(ReqFifoDepth + 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    typedef struct packed {
        logic [IdWidth-1:0]   id;
        logic [AddrWidth-1:0] src;
        logic [AddrWidth-1:0] dst;
        logic [AddrWidth-1:0] num_bytes;
        logic [AddrWidth-1:0] stride_src;
        logic [AddrWidth-1:0] stride_dst;
        logic [AddrWidth-1:0] num_reps;
        logic                 decouple_rw;
        logic                 is_twod;
    } req_t;

    req_t                 fifo_q [ReqFifoDepth];
    req_t                 in_req;
    req_t                 head;
    logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]      count_q;
    logic                 fifo_empty, fifo_full, push, pop;

    logic [0:0]           state_q;
    logic [IdWidth-1:0]   id_q;
    logic [AddrWidth-1:0] src_q, dst_q, num_bytes_q, stride_src_q, stride_dst_q, rem_q;
    logic [AddrWidth-1:0] load_rem;
    logic                 decouple_q, rem_is_one;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(ReqFifoDepth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign in_req = '{
        id:          twod_id_i,
        src:         twod_src_i,
        dst:         twod_dst_i,
        num_bytes:   twod_num_bytes_i,
        stride_src:  twod_stride_src_i,
        stride_dst:  twod_stride_dst_i,
        num_reps:    twod_num_reps_i,
        decouple_rw: twod_decouple_rw_i,
        is_twod:     twod_is_twod_i
    };

    assign fifo_empty   = (count_q == '0);
    assign fifo_full    = (count_q == CntW'(ReqFifoDepth));
    assign twod_ready_o = !fifo_full;
    assign push         = twod_valid_i && !fifo_full;
    assign head         = fifo_q[rd_ptr_q];
    assign rem_is_one   = (rem_q == AddrWidth'(1));

    // A head entry is taken when idle, or when the last burst of the active request handshakes.
    assign pop = !fifo_empty && ((state_q == IDLE) || (burst_ready_i && rem_is_one));

    // A zero repetition count still produces one burst so every request completes exactly once.
    assign load_rem = (head.is_twod && (head.num_reps != '0)) ? head.num_reps : AddrWidth'(1);

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_req;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            if (push && !pop)      count_q <= count_q + CntW'(1);
            else if (!push && pop) count_q <= count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            id_q         <= '0;
            src_q        <= '0;
            dst_q        <= '0;
            num_bytes_q  <= '0;
            stride_src_q <= '0;
            stride_dst_q <= '0;
            rem_q        <= '0;
            decouple_q   <= 1'b0;
        end else if (pop) begin
            state_q      <= ISSUE;
            id_q         <= head.id;
            src_q        <= head.src;
            dst_q        <= head.dst;
            num_bytes_q  <= head.num_bytes;
            stride_src_q <= head.stride_src;
            stride_dst_q <= head.stride_dst;
            rem_q        <= load_rem;
            decouple_q   <= head.decouple_rw;
        end else if ((state_q == ISSUE) && burst_ready_i) begin
            if (!rem_is_one) begin
                src_q <= src_q + stride_src_q;
                dst_q <= dst_q + stride_dst_q;
                rem_q <= rem_q - AddrWidth'(1);
            end else begin
                state_q <= IDLE;
            end
        end
    end

    assign burst_valid_o       = (state_q == ISSUE);
    assign burst_id_o          = id_q;
    assign burst_src_o         = src_q;
    assign burst_dst_o         = dst_q;
    assign burst_num_bytes_o   = num_bytes_q;
    assign burst_decouple_rw_o = decouple_q;
    assign burst_last_o        = (state_q == ISSUE) && rem_is_one;
    assign busy_o              = !fifo_empty || (state_q == ISSUE);

endmodule

// File: tb/tb_snax_dma_twod_expander.sv
// Directed bench for snax_dma_twod_expander: cycle-by-cycle vector table plus
// hand sequences for backpressure, FIFO fill and mid-expansion reset.
module tb_snax_dma_twod_expander;

    localparam int AW = 48;
    localparam int IW = 6;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          twod_valid_i;
    logic          twod_ready_o;
    logic [IW-1:0] twod_id_i;
    logic [AW-1:0] twod_src_i, twod_dst_i, twod_num_bytes_i;
    logic [AW-1:0] twod_stride_src_i, twod_stride_dst_i, twod_num_reps_i;
    logic          twod_decouple_rw_i, twod_is_twod_i;
    logic          burst_valid_o, burst_ready_i;
    logic [IW-1:0] burst_id_o;
    logic [AW-1:0] burst_src_o, burst_dst_o, burst_num_bytes_o;
    logic          burst_decouple_rw_o, burst_last_o, busy_o;

    int vec_count = 0;
    int err_count = 0;

    snax_dma_twod_expander dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .twod_valid_i(twod_valid_i), .twod_ready_o(twod_ready_o),
        .twod_id_i(twod_id_i), .twod_src_i(twod_src_i), .twod_dst_i(twod_dst_i),
        .twod_num_bytes_i(twod_num_bytes_i), .twod_stride_src_i(twod_stride_src_i),
        .twod_stride_dst_i(twod_stride_dst_i), .twod_num_reps_i(twod_num_reps_i),
        .twod_decouple_rw_i(twod_decouple_rw_i), .twod_is_twod_i(twod_is_twod_i),
        .burst_valid_o(burst_valid_o), .burst_ready_i(burst_ready_i),
        .burst_id_o(burst_id_o), .burst_src_o(burst_src_o), .burst_dst_o(burst_dst_o),
        .burst_num_bytes_o(burst_num_bytes_o), .burst_decouple_rw_o(burst_decouple_rw_o),
        .burst_last_o(burst_last_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic          v;
        logic [IW-1:0] id;
        logic [AW-1:0] src, dst, nb, ss, sd, reps;
        logic          is2d;
        logic          rdy;
        logic          e_trdy, e_val, e_last, e_busy;
        logic [IW-1:0] e_id;
        logic [AW-1:0] e_src, e_dst, e_nb;
    } vec_t;

    function automatic vec_t push_vec(input logic [IW-1:0] id, input logic [AW-1:0] src, dst, nb,
                                      ss, sd, reps, input logic is2d, input logic e_busy);
        vec_t r = '0;
        r.v = 1'b1; r.id = id; r.src = src; r.dst = dst; r.nb = nb;
        r.ss = ss; r.sd = sd; r.reps = reps; r.is2d = is2d; r.rdy = 1'b1;
        r.e_trdy = 1'b1; r.e_busy = e_busy;
        return r;
    endfunction

    function automatic vec_t wait_vec(input logic e_busy);
        vec_t r = '0;
        r.rdy = 1'b1; r.e_trdy = 1'b1; r.e_busy = e_busy;
        return r;
    endfunction

    function automatic vec_t burst_vec(input logic [IW-1:0] id, input logic [AW-1:0] src, dst, nb,
                                       input logic last);
        vec_t r = '0;
        r.rdy = 1'b1; r.e_trdy = 1'b1; r.e_val = 1'b1; r.e_busy = 1'b1; r.e_last = last;
        r.e_id = id; r.e_src = src; r.e_dst = dst; r.e_nb = nb;
        return r;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vec_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic setReq(input logic v, input logic [IW-1:0] id, input logic [AW-1:0] src, dst, nb,
                          ss, sd, reps, input logic is2d);
        twod_valid_i = v; twod_id_i = id; twod_src_i = src; twod_dst_i = dst;
        twod_num_bytes_i = nb; twod_stride_src_i = ss; twod_stride_dst_i = sd;
        twod_num_reps_i = reps; twod_is_twod_i = is2d; twod_decouple_rw_i = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t vec, input int idx);
        setReq(vec.v, vec.id, vec.src, vec.dst, vec.nb, vec.ss, vec.sd, vec.reps, vec.is2d);
        burst_ready_i = vec.rdy;
        @(negedge clk_i);
        checkOutput($sformatf("v%0d twod_ready", idx), 64'(twod_ready_o), 64'(vec.e_trdy));
        checkOutput($sformatf("v%0d burst_valid", idx), 64'(burst_valid_o), 64'(vec.e_val));
        checkOutput($sformatf("v%0d busy", idx), 64'(busy_o), 64'(vec.e_busy));
        checkOutput($sformatf("v%0d last", idx), 64'(burst_last_o), 64'(vec.e_last));
        if (vec.e_val) begin
            checkOutput($sformatf("v%0d id", idx), 64'(burst_id_o), 64'(vec.e_id));
            checkOutput($sformatf("v%0d src", idx), 64'(burst_src_o), 64'(vec.e_src));
            checkOutput($sformatf("v%0d dst", idx), 64'(burst_dst_o), 64'(vec.e_dst));
            checkOutput($sformatf("v%0d num_bytes", idx), 64'(burst_num_bytes_o), 64'(vec.e_nb));
        end
        step();
    endtask

    vec_t vecs [24];

    initial begin
        logic [AW-1:0] exp_src [5];
        int            got;
        logic          accept;

        vecs[0]  = push_vec(6'd1, 48'h1000, 48'h2000, 48'd64, 48'h0, 48'h0, 48'd0, 1'b0, 1'b0);
        vecs[1]  = wait_vec(1'b1);
        vecs[2]  = burst_vec(6'd1, 48'h1000, 48'h2000, 48'd64, 1'b1);
        vecs[3]  = wait_vec(1'b0);
        vecs[4]  = push_vec(6'd2, 48'h1000, 48'h2000, 48'd32, 48'h100, 48'h40, 48'd3, 1'b1, 1'b0);
        vecs[5]  = wait_vec(1'b1);
        vecs[6]  = burst_vec(6'd2, 48'h1000, 48'h2000, 48'd32, 1'b0);
        vecs[7]  = burst_vec(6'd2, 48'h1100, 48'h2040, 48'd32, 1'b0);
        vecs[8]  = burst_vec(6'd2, 48'h1200, 48'h2080, 48'd32, 1'b1);
        vecs[9]  = wait_vec(1'b0);
        vecs[10] = push_vec(6'd3, 48'h5000, 48'h6000, 48'd0, 48'h0, 48'h0, 48'd0, 1'b1, 1'b0);
        vecs[11] = wait_vec(1'b1);
        vecs[12] = burst_vec(6'd3, 48'h5000, 48'h6000, 48'd0, 1'b1);
        vecs[13] = wait_vec(1'b0);
        vecs[14] = push_vec(6'd4, 48'hFFFF_FFFF_FFF0, 48'h10, 48'd4, 48'h20, 48'h8, 48'd2, 1'b1, 1'b0);
        vecs[15] = wait_vec(1'b1);
        vecs[16] = burst_vec(6'd4, 48'hFFFF_FFFF_FFF0, 48'h10, 48'd4, 1'b0);
        vecs[17] = burst_vec(6'd4, 48'h10, 48'h18, 48'd4, 1'b1);
        vecs[18] = wait_vec(1'b0);
        // is_twod=0 must ignore a nonzero repetition count
        vecs[19] = push_vec(6'd5, 48'hA000, 48'hB000, 48'd8, 48'h4, 48'h4, 48'd7, 1'b0, 1'b0);
        vecs[20] = push_vec(6'd6, 48'hA100, 48'hB100, 48'd16, 48'h0, 48'h0, 48'd0, 1'b0, 1'b1);
        vecs[21] = burst_vec(6'd5, 48'hA000, 48'hB000, 48'd8, 1'b1);
        vecs[22] = burst_vec(6'd6, 48'hA100, 48'hB100, 48'd16, 1'b1);
        vecs[23] = wait_vec(1'b0);

        rst_i = 1'b1;
        burst_ready_i = 1'b1;
        setReq(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        step();
        step();
        checkOutput("reset burst_valid", 64'(burst_valid_o), 64'd0);
        checkOutput("reset busy", 64'(busy_o), 64'd0);
        checkOutput("reset twod_ready", 64'(twod_ready_o), 64'd1);
        checkOutput("reset last", 64'(burst_last_o), 64'd0);
        checkOutput("reset src", 64'(burst_src_o), 64'd0);
        checkOutput("reset id", 64'(burst_id_o), 64'd0);
        rst_i = 1'b0;

        for (int i = 0; i < 24; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Backpressure mid-2D: the second repetition must hold until accepted
        setReq(1'b1, 6'd7, 48'h3000, 48'h4000, 48'd4, 48'h10, 48'h20, 48'd3, 1'b1);
        step();
        setReq(1'b0, '0, '0, '0, '0, '0, '0, '0, 1'b0);
        step();
        checkOutput("bp rep1 src", 64'(burst_src_o), 64'h3000);
        step();
        burst_ready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checkOutput($sformatf("bp hold%0d valid", c), 64'(burst_valid_o), 64'd1);
            checkOutput($sformatf("bp hold%0d src", c), 64'(burst_src_o), 64'h3010);
            checkOutput($sformatf("bp hold%0d dst", c), 64'(burst_dst_o), 64'h4020);
            checkOutput($sformatf("bp hold%0d last", c), 64'(burst_last_o), 64'd0);
        end
        burst_ready_i = 1'b1;
        checkOutput("bp resume src", 64'(burst_src_o), 64'h3010);
        step();
        checkOutput("bp rep3 src", 64'(burst_src_o), 64'h3020);
        checkOutput("bp rep3 last", 64'(burst_last_o), 64'd1);
        step();
        checkOutput("bp done valid", 64'(burst_valid_o), 64'd0);

        // Fill: A in working regs, B..D in FIFO, E stalls
        burst_ready_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            exp_src[k] = 48'h100 * AW'(k + 1);
            setReq(1'b1, IW'(k + 10), exp_src[k], 48'h0, 48'd1, '0, '0, '0, 1'b0);
            checkOutput($sformatf("fill push%0d ready", k), 64'(twod_ready_o), (k < 4) ? 64'd1 : 64'd0);
            if (k < 4) step();
        end
        step();
        step();
        checkOutput("fill E still stalled", 64'(twod_ready_o), 64'd0);
        checkOutput("fill A at output", 64'(burst_src_o), 64'h100);
        burst_ready_i = 1'b1;
        got = 0;
        for (int c = 0; c < 30 && got < 5; c++) begin
            if (burst_valid_o) begin
                checkOutput($sformatf("fill drain%0d src", got), 64'(burst_src_o), 64'(exp_src[got]));
                got++;
            end
            accept = twod_valid_i && twod_ready_o;
            step();
            if (accept) twod_valid_i = 1'b0;
        end
        checkOutput("fill drain count", 64'(got), 64'd5);
        step();
        checkOutput("fill idle busy", 64'(busy_o), 64'd0);

        // Reset during repetition 2 of 4 with another request queued
        setReq(1'b1, 6'd20, 48'h8000, 48'h9000, 48'd2, 48'h4, 48'h4, 48'd4, 1'b1);
        step();
        setReq(1'b1, 6'd21, 48'hC000, 48'hD000, 48'd2, '0, '0, '0, 1'b0);
        step();
        twod_valid_i = 1'b0;
        step();
        checkOutput("rst rep2 src", 64'(burst_src_o), 64'h8004);
        rst_i = 1'b1;
        #1;
        checkOutput("rst burst_valid", 64'(burst_valid_o), 64'd0);
        checkOutput("rst busy", 64'(busy_o), 64'd0);
        step();
        rst_i = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checkOutput($sformatf("post-rst%0d valid", c), 64'(burst_valid_o), 64'd0);
            checkOutput($sformatf("post-rst%0d twod_ready", c), 64'(twod_ready_o), 64'd1);
            checkOutput($sformatf("post-rst%0d busy", c), 64'(busy_o), 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
